// File: rtl/cfg_loader_pea_pkg.sv
// rtl/cfg_loader_pea_pkg.sv - PEA geometry, configuration stream constants and loader state type
package cfg_loader_pea_pkg;

  localparam int N             = 2;
  localparam int M             = 2;
  localparam int KMEM_SIZE     = 2;
  localparam int N_CFG_BITS_PE = 40;

  localparam int CFG_WORD_W        = 32;
  localparam int CFG_WPE           = (N_CFG_BITS_PE + CFG_WORD_W - 1) / CFG_WORD_W;
  localparam int N_CFG_WORDS_TOTAL = N * KMEM_SIZE * M * CFG_WPE;

  // Counter width for a 0..n-1 range; single-value ranges still get one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int W_W = cnt_w(CFG_WPE);
  localparam int J_W = cnt_w(M);
  localparam int T_W = cnt_w(KMEM_SIZE);
  localparam int I_W = cnt_w(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } cfg_load_state_t;

endpackage

// File: rtl/cfg_loader_pea_if.sv
// rtl/cfg_loader_pea_if.sv - configuration word stream between system port and loader
interface cfg_loader_pea_if;
  import cfg_loader_pea_pkg::*;

  logic                  cfg_valid;
  logic [CFG_WORD_W-1:0] cfg_data;
  logic                  cfg_ready;

  modport master (output cfg_valid, output cfg_data, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_data, output cfg_ready);

endinterface

// File: rtl/cfg_loader_pea_packer.sv
// rtl/cfg_loader_pea_packer.sv - gathers CFG_WPE little-endian stream words into one PE entry
module cfg_word_packer
  import cfg_loader_pea_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     accept,
  input  logic [CFG_WORD_W-1:0]    data,
  output logic [N_CFG_BITS_PE-1:0] entry,
  output logic                     entry_valid
);

  logic [W_W-1:0] w_q;
  logic           last_word;

  assign last_word   = (w_q == W_W'(CFG_WPE - 1));
  assign entry_valid = accept && last_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q <= '0;
    end else if (clr) begin
      w_q <= '0;
    end else if (accept) begin
      w_q <= last_word ? '0 : w_q + 1'b1;
    end
  end

  generate
    if (CFG_WPE > 1) begin : g_hold
      logic [(CFG_WPE-1)*CFG_WORD_W-1:0] hold_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hold_q <= '0;
        end else if (clr) begin
          hold_q <= '0;
        end else if (accept && !last_word) begin
          hold_q[w_q*CFG_WORD_W +: CFG_WORD_W] <= data;
        end
      end

      // Current word is the most significant; pad bits of the last word fall off here.
      assign entry = N_CFG_BITS_PE'({data, hold_q});
    end else begin : g_single
      assign entry = N_CFG_BITS_PE'(data);
    end
  endgenerate

endmodule

// File: rtl/cfg_loader_pea.sv
// rtl/cfg_loader_pea.sv - loads the per-PE, per-slot configuration storage from the word stream
module cfg_loader_pea
  import cfg_loader_pea_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     start_i,
  cfg_loader_pea_if.slave          cfg,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     cfg_loaded_o,
  output logic [N_CFG_BITS_PE-1:0] reg_cfg_pea_o [N][M][KMEM_SIZE]
);

  cfg_load_state_t state_q, state_d;

  logic                     accept;
  logic                     start_acc;
  logic                     entry_valid;
  logic                     final_hs;
  logic [N_CFG_BITS_PE-1:0] entry;
  logic [J_W-1:0]           j_q;
  logic [T_W-1:0]           t_q;
  logic [I_W-1:0]           i_q;
  logic                     last_j, last_t, last_i;
  logic                     loaded_q;

  assign cfg.cfg_ready = (state_q == LOAD);
  assign accept        = cfg.cfg_valid && cfg.cfg_ready;
  assign start_acc     = start_i && (state_q == IDLE);
  assign busy_o        = (state_q != IDLE);
  assign done_o        = (state_q == DONE);
  assign cfg_loaded_o  = loaded_q;

  assign last_j   = (j_q == J_W'(M - 1));
  assign last_t   = (t_q == T_W'(KMEM_SIZE - 1));
  assign last_i   = (i_q == I_W'(N - 1));
  assign final_hs = entry_valid && last_j && last_t && last_i;

  cfg_word_packer u_packer (
    .clk         (clk_i),
    .rst_n       (rst_n_i),
    .clr         (start_acc),
    .accept      (accept),
    .data        (cfg.cfg_data),
    .entry       (entry),
    .entry_valid (entry_valid)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = LOAD;
      LOAD:    if (final_hs) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Column is innermost, then slot, then row, matching the stream order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      j_q <= '0;
      t_q <= '0;
      i_q <= '0;
    end else if (start_acc) begin
      j_q <= '0;
      t_q <= '0;
      i_q <= '0;
    end else if (entry_valid) begin
      j_q <= last_j ? '0 : j_q + 1'b1;
      if (last_j) begin
        t_q <= last_t ? '0 : t_q + 1'b1;
        if (last_t) begin
          i_q <= last_i ? '0 : i_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      loaded_q <= 1'b0;
    end else if (start_acc) begin
      loaded_q <= 1'b0;
    end else if (final_hs) begin
      loaded_q <= 1'b1;
    end
  end

  // A new load does not clear storage; entries are overwritten one by one.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int a = 0; a < N; a++)
        for (int b = 0; b < M; b++)
          for (int c = 0; c < KMEM_SIZE; c++)
            reg_cfg_pea_o[a][b][c] <= '0;
    end else if (entry_valid) begin
      reg_cfg_pea_o[i_q][j_q][t_q] <= entry;
    end
  end

endmodule

// File: tb/tb_cfg_loader_pea.sv
// tb/tb_cfg_loader_pea.sv - self-checking bench for cfg_loader_pea against a stream-order reference model
module tb_cfg_loader_pea;
  import cfg_loader_pea_pkg::*;

  localparam int TOT = N_CFG_WORDS_TOTAL;

  typedef struct {
    int pat;
    int max_gap;
    bit start_mid;
    bit start_final;
    int exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done, loaded;
  logic [N_CFG_BITS_PE-1:0] reg_cfg [N][M][KMEM_SIZE];

  cfg_loader_pea_if cfg_if ();

  cfg_loader_pea dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .start_i       (start),
    .cfg           (cfg_if),
    .busy_o        (busy),
    .done_o        (done),
    .cfg_loaded_o  (loaded),
    .reg_cfg_pea_o (reg_cfg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  logic [N_CFG_BITS_PE-1:0]       exp_mem [N][M][KMEM_SIZE];
  logic [CFG_WPE*CFG_WORD_W-1:0]  acc;
  vec_t                           vecs [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic clear_model();
    for (int a = 0; a < N; a++)
      for (int b = 0; b < M; b++)
        for (int c = 0; c < KMEM_SIZE; c++)
          exp_mem[a][b][c] = '0;
  endtask

  task automatic cmp_all(input string tag);
    for (int a = 0; a < N; a++)
      for (int b = 0; b < M; b++)
        for (int c = 0; c < KMEM_SIZE; c++)
          check($sformatf("%s[%0d][%0d][%0d]", tag, a, b, c),
                64'(reg_cfg[a][b][c]), 64'(exp_mem[a][b][c]));
  endtask

  function automatic logic [31:0] word_of(input int pat, input int k);
    case (pat)
      0:       return 32'h1000_0000 + 32'(k);
      1:       return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  // Stream word k lands in entry [i][j][t], word slot w, by stream-order position arithmetic.
  task automatic model_word(input int k, input logic [31:0] d, output bit complete,
                            output int ri, output int rj, output int rt);
    int w;
    w  = k % CFG_WPE;
    rj = (k / CFG_WPE) % M;
    rt = (k / (CFG_WPE * M)) % KMEM_SIZE;
    ri = k / (CFG_WPE * M * KMEM_SIZE);
    acc[w*CFG_WORD_W +: CFG_WORD_W] = d;
    complete = (w == CFG_WPE - 1);
    if (complete) exp_mem[ri][rj][rt] = acc[N_CFG_BITS_PE-1:0];
  endtask

  task automatic push_word(input int k, input logic [31:0] d, input bit with_start);
    bit complete;
    int ri, rj, rt;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_data  = d;
    if (with_start) start = 1'b1;
    check("ready_in_load", 64'(cfg_if.cfg_ready), 64'd1);
    @(posedge clk); #1;
    cfg_if.cfg_valid = 1'b0;
    start = 1'b0;
    model_word(k, d, complete, ri, rj, rt);
    if (complete)
      check($sformatf("entry_wr[%0d][%0d][%0d]", ri, rj, rt),
            64'(reg_cfg[ri][rj][rt]), 64'(exp_mem[ri][rj][rt]));
  endtask

  task automatic begin_load();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("ready_after_start", 64'(cfg_if.cfg_ready), 64'd1);
    check("busy_after_start", 64'(busy), 64'd1);
    check("loaded_cleared", 64'(loaded), 64'd0);
  endtask

  task automatic run_load(input vec_t v);
    int c0, d0, gap;
    d0 = done_cnt;
    c0 = cyc;
    begin_load();
    for (int k = 0; k < TOT; k++) begin
      gap = int'($urandom_range(0, v.max_gap));
      for (int g = 0; g < gap; g++) begin
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_data  = $urandom();
        @(posedge clk); #1;
      end
      push_word(k, word_of(v.pat, k),
                (v.start_mid && k == 5) || (v.start_final && k == TOT - 1));
    end
    check("ready_after_final", 64'(cfg_if.cfg_ready), 64'd0);
    check("done_after_final", 64'(done), 64'd1);
    check("loaded_after_final", 64'(loaded), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", 64'(done_cnt - d0), 64'd1);
    if (v.exp_lat >= 0) check("done_latency", 64'(done_cyc - c0), 64'(v.exp_lat));
    check("busy_end", 64'(busy), 64'd0);
    check("ready_end", 64'(cfg_if.cfg_ready), 64'd0);
    check("loaded_end", 64'(loaded), 64'd1);
    cmp_all("final");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{pat: 0, max_gap: 0, start_mid: 1'b0, start_final: 1'b0, exp_lat: TOT + 1};
    vecs[1] = '{pat: 0, max_gap: 5, start_mid: 1'b1, start_final: 1'b0, exp_lat: -1};
    vecs[2] = '{pat: 1, max_gap: 0, start_mid: 1'b0, start_final: 1'b0, exp_lat: TOT + 1};
    vecs[3] = '{pat: 2, max_gap: 3, start_mid: 1'b0, start_final: 1'b1, exp_lat: -1};

    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_data  = $urandom();
    acc = '0;
    clear_model();

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 64'(cfg_if.cfg_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_loaded", 64'(loaded), 64'd0);
    cmp_all("rst");
    rst_n = 1'b1;

    // Valid held high with no start: nothing may be accepted.
    for (int c = 0; c < 5; c++) begin
      cfg_if.cfg_data = $urandom();
      @(posedge clk); #1;
      check("idle_ready", 64'(cfg_if.cfg_ready), 64'd0);
    end
    cfg_if.cfg_valid = 1'b0;
    check("idle_busy", 64'(busy), 64'd0);
    cmp_all("idle");

    for (int v = 0; v < 4; v++) run_load(vecs[v]);

    // Reset partway through a load zeroes storage and flags.
    begin_load();
    for (int k = 0; k < 4; k++) push_word(k, word_of(0, k), 1'b0);
    rst_n = 1'b0;
    #1;
    clear_model();
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_ready", 64'(cfg_if.cfg_ready), 64'd0);
    check("midrst_loaded", 64'(loaded), 64'd0);
    cmp_all("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_idle", 64'(busy), 64'd0);
    run_load(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
